lfsr_prng: RTL and testbench
============================

Name: lfsr_prng

Overview:
Parametrised Fibonacci-LFSR pseudo-random word generator, the successor to the fixed 16-bit shift-enable LFSR. It adds generic width, a runtime polynomial, STEPS shifts per advance, and a counted-burst request/valid-ready output handshake. It feeds stochastic neuron/synapse units (Poisson spike compare, stochastic rounding), which consume words at their own rate.

Parameters:
WIDTH, 16, LFSR state/output width (>=4)
STEPS, 1, LFSR shifts applied per advance (1..WIDTH), unrolled combinationally
CNT_W, 8, width of burst word count
LOCKUP_SEED, 1, substitute seed used by the lockup guard (nonzero, WIDTH bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
seed  in  WIDTH  seed value, sampled on rst or seed_load
poly  in  WIDTH  tap mask, sampled with seed
seed_load  in  1  load seed/poly (honoured only in IDLE)
req_valid  in  1  burst request
req_count  in  CNT_W  number of words in burst
req_ready  out  1  request accepted when req_valid && req_ready
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts word
out_data  out  WIDTH  random word (= state register)
busy  out  1  high in GEN
lockup_err  out  1  sticky zero-seed flag (optional feature)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Single shift: fb = ^(state & poly_r); state_next = {fb, state[WIDTH-1:1]}. An advance applies the single shift STEPS times in one cycle.
- Reset values:
  - state <= seed, poly_r <= poly, FSM = IDLE.
  - req_ready=1, out_valid=0, busy=0, lockup_err=0.
  - out_data shows state at all times.
- FSM IDLE:
  - req_ready=1, out_valid=0.
  - seed_load=1: state<=seed, poly_r<=poly.
  - req_valid with req_count==0: accepted and dropped; stays IDLE, no advance.
  - req_valid with req_count=N>0: remaining<=N, state advances once, go to GEN. out_valid is high the next cycle (latency 1).
  - seed_load and accepted request in the same cycle: the seed is loaded and the advance is applied to the loaded seed, so the first word is derived from the new seed.
- FSM GEN:
  - req_ready=0, busy=1, out_valid=1.
  - Handshake (out_valid && out_ready) with remaining>1: advance state, remaining--.
  - Handshake with remaining==1: go to IDLE with no advance. out_valid=0 the next cycle.
  - Net effect: a burst of N words performs exactly N advances.
  - out_ready low: state and out_data hold stable; no advance.
  - seed_load is ignored in GEN.
- Outputs are all registered or decoded from state; there is no combinational input-to-output path.
- rst mid-burst: aborts the burst immediately. Next cycle is IDLE with state=seed and out_valid=0.
- poly_r==0: sequence shifts zeros in; this is legal and not flagged.
- remaining is CNT_W bits; max burst is 2^CNT_W-1.

Optional Feature:
Macro LFSR_LOCKUP_GUARD_EN.
- Defined: whenever the seed is loaded (rst or honoured seed_load) with seed==0, state<=LOCKUP_SEED and lockup_err<=1. lockup_err is sticky until rst, or a seed_load with a nonzero seed, which clears it.
- Undefined: a zero seed is loaded as-is (state stays 0 forever); lockup_err is tied 0.

Test Plan:
1. WIDTH=16, STEPS=1, poly=0x080B, seed=0x0001, rst, then request N=6 with out_ready=1 -> words 0x8000, 0x4000, 0x2000, 0x1000, 0x0800, 0x8400 on consecutive cycles; out_valid falls after the 6th; req_ready returns 1.
2. STEPS=4, same poly/seed, N=2 -> words 0x1000, 0x2100.
3. Backpressure: N=3, out_ready low for 5 cycles after the first word -> out_data stays 0x8000 with out_valid=1. When out_ready rises, 0x8000, 0x4000, 0x2000 are delivered.
4. req_count=0 -> accepted (req_ready=1); out_valid never rises, state unchanged. Then seed_load=1 with req_valid=1, seed=0x0001, N=1 from state 0xACE1 -> single word 0x8000.
5. rst asserted during the second word of an N=10 burst (seed=0x0001) -> next cycle out_valid=0, busy=0, out_data=0x0001, req_ready=1. seed_load issued during GEN is ignored.
6. LFSR_LOCKUP_GUARD_EN defined, seed=0 at rst -> state=0x0001, lockup_err=1; seed_load seed=0x0003 clears it. Undefined: seed=0 gives all-zero words and lockup_err=0.

Source files
------------

// File: rtl/lfsr_prng_if.sv
// Request and output-word handshake bundle for lfsr_prng.
// The generator (master) accepts bursts and sources words; the consumer (slave) does the opposite.
interface lfsr_prng_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic [CNT_W-1:0] req_count;
  logic             req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  req_valid, req_count, out_ready,
    output req_ready, out_valid, out_data
  );

  modport slave (
    output req_valid, req_count, out_ready,
    input  req_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_prng.sv
// Fibonacci-LFSR word generator with runtime tap mask, STEPS shifts per advance and counted bursts.
// Optional zero-seed lockup guard enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_prng #(
  parameter int               WIDTH       = 16,
  parameter int               STEPS       = 1,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] LOCKUP_SEED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] poly,
  input  logic             seed_load,
  lfsr_prng_if.master      bus,
  output logic             busy,
  output logic             lockup_err
);

`ifdef LFSR_LOCKUP_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} fsm_t;

  fsm_t             fsm_reg, fsm_next;
  logic [WIDTH-1:0] lfsr_reg, lfsr_next;
  logic [WIDTH-1:0] poly_reg, poly_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             lock_reg, lock_next;

  logic             seed_zero;
  logic [WIDTH-1:0] seed_eff;
  logic             load_now;
  logic [WIDTH-1:0] adv_poly;
  logic [WIDTH-1:0] chain [STEPS+1];

  assign seed_zero = GUARD_EN && (seed == '0);
  assign seed_eff  = seed_zero ? LOCKUP_SEED : seed;

  // A seed load coinciding with an accepted request must advance from the new seed and taps.
  assign load_now = (fsm_reg == IDLE) && seed_load;
  assign chain[0] = load_now ? seed_eff : lfsr_reg;
  assign adv_poly = load_now ? poly : poly_reg;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_shift
      assign chain[gi+1] = {^(chain[gi] & adv_poly), chain[gi][WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg  <= IDLE;
      lfsr_reg <= seed_eff;
      poly_reg <= poly;
      rem_reg  <= '0;
      lock_reg <= seed_zero;
    end else begin
      fsm_reg  <= fsm_next;
      lfsr_reg <= lfsr_next;
      poly_reg <= poly_next;
      rem_reg  <= rem_next;
      lock_reg <= lock_next;
    end
  end

  always_comb begin
    fsm_next  = fsm_reg;
    lfsr_next = lfsr_reg;
    poly_next = poly_reg;
    rem_next  = rem_reg;
    lock_next = lock_reg;
    case (fsm_reg)
      IDLE: begin
        if (seed_load) begin
          lfsr_next = seed_eff;
          poly_next = poly;
          lock_next = seed_zero;
        end
        // A zero-length request is accepted and discarded.
        if (bus.req_valid && (bus.req_count != '0)) begin
          rem_next  = bus.req_count;
          lfsr_next = chain[STEPS];
          fsm_next  = GEN;
        end
      end
      GEN: begin
        // The first word was produced on entry, so the last handshake must not advance.
        if (bus.out_ready) begin
          if (rem_reg == CNT_W'(1)) begin
            fsm_next = IDLE;
          end else begin
            lfsr_next = chain[STEPS];
            rem_next  = rem_reg - CNT_W'(1);
          end
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign bus.req_ready = (fsm_reg == IDLE);
  assign bus.out_valid = (fsm_reg == GEN);
  assign bus.out_data  = lfsr_reg;
  assign busy          = (fsm_reg == GEN);
  assign lockup_err    = GUARD_EN ? lock_reg : 1'b0;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed self-checking bench for lfsr_prng: a STEPS=1 instance for the main tests and
// a STEPS=4 instance for the multi-shift advance.
module tb_lfsr_prng;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] seed;
  logic [15:0] poly;
  logic        seed_load;
  logic        busy, lockup_err;
  logic        busy4, lockup_err4;

  int n_cmp = 0;
  int n_bad = 0;

  lfsr_prng_if #(.WIDTH(16), .CNT_W(8)) bus  ();
  lfsr_prng_if #(.WIDTH(16), .CNT_W(8)) bus4 ();

  lfsr_prng #(.WIDTH(16), .STEPS(1), .CNT_W(8), .LOCKUP_SEED(16'h0001)) dut (
    .clk(clk), .rst(rst), .seed(seed), .poly(poly), .seed_load(seed_load),
    .bus(bus), .busy(busy), .lockup_err(lockup_err)
  );

  lfsr_prng #(.WIDTH(16), .STEPS(4), .CNT_W(8), .LOCKUP_SEED(16'h0001)) dut4 (
    .clk(clk), .rst(rst), .seed(seed), .poly(poly), .seed_load(seed_load),
    .bus(bus4), .busy(busy4), .lockup_err(lockup_err4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          start;     // reset with seed 0x0001 and issue a request of `count` first
    logic [7:0]  count;
    logic        rdy;       // out_ready driven for the following cycle
    logic [15:0] exp_data;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [$];

  // Advance to 1 time unit past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic do_reset(input logic [15:0] s);
    rst = 1'b1; seed = s; poly = 16'h080B; seed_load = 1'b0;
    bus.req_valid = 1'b0; bus.req_count = '0; bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic request(input logic [7:0] n);
    bus.req_valid = 1'b1; bus.req_count = n; bus.out_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  function automatic vec_t mk(input bit st, input logic [7:0] c, input logic r,
                              input logic [15:0] d, input logic v);
    vec_t x;
    x.start = st; x.count = c; x.rdy = r; x.exp_data = d; x.exp_valid = v;
    return x;
  endfunction

  initial begin
    rst = 1'b1; seed = 16'h0001; poly = 16'h080B; seed_load = 1'b0;
    bus.req_valid = 1'b0; bus.req_count = '0; bus.out_ready = 1'b0;
    bus4.req_valid = 1'b0; bus4.req_count = '0; bus4.out_ready = 1'b0;

    // Burst of 6, consumer always ready.
    vecs.push_back(mk(1, 8'd6, 1, 16'h8000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h4000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h2000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h1000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h0800, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h8400, 1));
    vecs.push_back(mk(0, 8'd0, 0, 16'h8400, 0));
    // Burst of 3 with five stalled cycles after the first word.
    vecs.push_back(mk(1, 8'd3, 0, 16'h8000, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 8'd0, 0, 16'h8000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h8000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h4000, 1));
    vecs.push_back(mk(0, 8'd0, 1, 16'h2000, 1));
    vecs.push_back(mk(0, 8'd0, 0, 16'h2000, 0));

    // Reset state.
    do_reset(16'h0001);
    check("reset out_data", bus.out_data, 16'h0001);
    check("reset req_ready", bus.req_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", busy, 0);
    check("reset lockup_err", lockup_err, 0);

    foreach (vecs[i]) begin
      if (vecs[i].start) begin
        do_reset(16'h0001);
        request(vecs[i].count);
      end
      check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].exp_data);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d req_ready", i), bus.req_ready, !vecs[i].exp_valid);
      bus.out_ready = vecs[i].rdy;
      step();
    end

    // STEPS=4 instance: two words.
    do_reset(16'h0001);
    bus4.req_valid = 1'b1; bus4.req_count = 8'd2; bus4.out_ready = 1'b1;
    step();
    bus4.req_valid = 1'b0;
    check("steps4 word0", bus4.out_data, 16'h1000);
    check("steps4 valid0", bus4.out_valid, 1);
    step();
    check("steps4 word1", bus4.out_data, 16'h2100);
    step();
    check("steps4 done valid", bus4.out_valid, 0);
    check("steps4 done busy", busy4, 0);
    bus4.out_ready = 1'b0;

    // Zero-length request, then seed_load combined with a request.
    do_reset(16'h0001);
    seed = 16'hACE1; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("seed_load ACE1", bus.out_data, 16'hACE1);
    check("zero req ready", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_count = 8'd0; bus.out_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("zero req valid c%0d", k), bus.out_valid, 0);
      check($sformatf("zero req data c%0d", k), bus.out_data, 16'hACE1);
      step();
    end
    seed = 16'h0001; seed_load = 1'b1;
    bus.req_valid = 1'b1; bus.req_count = 8'd1;
    step();
    seed_load = 1'b0; bus.req_valid = 1'b0;
    check("load+req word", bus.out_data, 16'h8000);
    check("load+req valid", bus.out_valid, 1);
    step();
    check("load+req end valid", bus.out_valid, 0);
    check("load+req end data", bus.out_data, 16'h8000);

    // Reset mid-burst; seed_load during GEN is ignored.
    do_reset(16'h0001);
    request(8'd10);
    check("abort word1", bus.out_data, 16'h8000);
    seed = 16'h1234; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("gen seed_load ignored", bus.out_data, 16'h4000);
    check("gen busy", busy, 1);
    seed = 16'h0001; rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort out_valid", bus.out_valid, 0);
    check("abort busy", busy, 0);
    check("abort out_data", bus.out_data, 16'h0001);
    check("abort req_ready", bus.req_ready, 1);

    // Zero seed handling.
    do_reset(16'h0000);
`ifdef LFSR_LOCKUP_GUARD_EN
    check("zero seed substituted", bus.out_data, 16'h0001);
    check("zero seed lockup_err", lockup_err, 1);
    request(8'd1);
    check("lockup sticky", lockup_err, 1);
    step();
    seed = 16'h0003; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("lockup cleared", lockup_err, 0);
    check("reload data", bus.out_data, 16'h0003);
`else
    check("zero seed data", bus.out_data, 16'h0000);
    check("zero seed lockup_err", lockup_err, 0);
    request(8'd2);
    check("zero word0", bus.out_data, 16'h0000);
    check("zero word0 valid", bus.out_valid, 1);
    step();
    check("zero word1", bus.out_data, 16'h0000);
    check("zero lockup_err after", lockup_err, 0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
